logicnet_input_packer: RTL

Upstream feeder for the layer-0 neuron LUT array of the LogicNet classifier. Accepts one raw unsigned feature per beat over a valid/ready stream, quantizes each feature to FEATURE_BITS, and packs a full sample into the flat input vector consumed by layer 0. It double-buffers, so one sample can be assembled while the previous one is held for layer 0, and it detects sample-length framing errors.

---
 rtl/logicnet_input_packer.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/logicnet_input_packer.sv
// logicnet_input_packer: quantizes one raw feature per beat and packs complete samples
// into a double-buffered flat vector for layer 0. Define LOGICNET_PACK_ROUND_EN for round-half-up.
module logicnet_input_packer #(
  parameter int unsigned NUM_FEATURES = 16,
  parameter int unsigned IN_WIDTH     = 8,
  parameter int unsigned FEATURE_BITS = 2,
  localparam int unsigned OUT_WIDTH   = NUM_FEATURES * FEATURE_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [IN_WIDTH-1:0]  s_data,
  input  logic                 s_last,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [OUT_WIDTH-1:0] m_data,
  output logic                 err_len
);

  localparam int unsigned SHIFT    = IN_WIDTH - FEATURE_BITS;
  localparam int unsigned CNT_W    = $clog2(NUM_FEATURES);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_FEATURES - 1);

`ifdef LOGICNET_PACK_ROUND_EN
  localparam logic [IN_WIDTH:0] HALF = (IN_WIDTH + 1)'(1) << (SHIFT - 1);
  localparam logic [IN_WIDTH:0] QMAX = (IN_WIDTH + 1)'((1 << FEATURE_BITS) - 1);
`endif

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [OUT_WIDTH-1:0]   asm_q, asm_d, asm_ins_c;
  logic                   ovl_q, ovl_d;
  logic                   s_ready_d, m_valid_d, err_d, load_c;
  logic [OUT_WIDTH-1:0]   m_data_d;
  logic [FEATURE_BITS-1:0] q_c;
  logic                   beat_c, drain_c, room_c, is_end_c;

  // Feature quantizer; rounding adds half an LSB at IN_WIDTH+1 bits and saturates.
  function automatic logic [FEATURE_BITS-1:0] quant(input logic [IN_WIDTH-1:0] d);
`ifdef LOGICNET_PACK_ROUND_EN
    logic [IN_WIDTH:0] sum;
    logic [IN_WIDTH:0] r;
    sum = {1'b0, d} + HALF;
    r   = sum >> SHIFT;
    return (r > QMAX) ? '1 : FEATURE_BITS'(r);
`else
    return FEATURE_BITS'(d >> SHIFT);
`endif
  endfunction

  assign q_c      = quant(s_data);
  assign beat_c   = s_valid && s_ready;
  assign drain_c  = m_valid && m_ready;
  assign room_c   = !m_valid || m_ready;
  assign is_end_c = (cnt_q == LAST_IDX);

  // Assembly vector with the current beat's feature already in place.
  always_comb begin
    asm_ins_c = asm_q;
    asm_ins_c[32'(cnt_q) * FEATURE_BITS +: FEATURE_BITS] = q_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      cnt_q   <= '0;
      asm_q   <= '0;
      ovl_q   <= 1'b0;
      s_ready <= 1'b0;
      m_valid <= 1'b0;
      m_data  <= '0;
      err_len <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      ovl_q   <= ovl_d;
      s_ready <= s_ready_d;
      m_valid <= m_valid_d;
      m_data  <= m_data_d;
      err_len <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FILL: begin
        if (beat_c && is_end_c) begin
          if (!room_c)      state_d = HOLD;
          else if (!s_last) state_d = DRAIN;
        end
      end
      HOLD: begin
        if (drain_c) state_d = ovl_q ? DRAIN : FILL;
      end
      DRAIN: begin
        if (beat_c && s_last) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  // Datapath and registered-output next values.
  always_comb begin
    cnt_d  = cnt_q;
    asm_d  = asm_q;
    ovl_d  = ovl_q;
    err_d  = 1'b0;
    load_c = 1'b0;
    case (state_q)
      FILL: begin
        if (beat_c) begin
          asm_d = asm_ins_c;
          if (is_end_c) begin
            cnt_d  = '0;
            err_d  = !s_last;
            ovl_d  = !s_last;
            load_c = room_c;
          end else if (s_last) begin
            cnt_d = '0;
            err_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      HOLD:    load_c = drain_c;
      default: ;
    endcase
    m_valid_d = load_c || (m_valid && !m_ready);
    m_data_d  = load_c ? asm_d : m_data;
    s_ready_d = (state_d != HOLD);
  end

endmodule
